codificador_instrucao: RTL and testbench

CODIFICADOR_INSTRUCAO -- requirements
Module: codificador_instrucao

---
 rtl/codificador_instrucao.sv | 127 ++++++++++++
 tb/tb_codificador_instrucao.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_instrucao.sv
// Encodes RV32I instruction descriptions into 32-bit words and writes them
// sequentially into a 256-word instruction memory, one word every two cycles.
module codificador_instrucao (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  count,
  output logic        full,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    FULL_ST = 2'd2
  } state_t;

  localparam logic [2:0] OP_LW      = 3'd0;
  localparam logic [2:0] OP_SW      = 3'd1;
  localparam logic [2:0] OP_SUB     = 3'd2;
  localparam logic [2:0] OP_XOR     = 3'd3;
  localparam logic [2:0] OP_ADDI    = 3'd4;
  localparam logic [2:0] OP_SRL     = 3'd5;
  localparam logic [2:0] OP_BEQ     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  state_t      state, state_next;
  logic [7:0]  ptr, ptr_next;
  logic [8:0]  cnt, cnt_next;
  logic [31:0] word_q, word_next;
  logic        err_q, err_next;
  logic        accept;
  logic [31:0] encoded;

  // Handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both high; a simultaneous clear cancels the transfer.
  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~clear;

  // For beq, imm carries byte-offset bits [12:1], so imm[11] is offset bit 12
  // and imm[10] is offset bit 11.
  always_comb begin
    encoded = 32'd0;
    unique case (op_sel)
      OP_LW:   encoded = {imm, rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   encoded = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_SUB:  encoded = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_XOR:  encoded = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      OP_ADDI: encoded = {imm, rs1, 3'b000, rd, 7'b0010011};
      OP_SRL:  encoded = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0110011};
      OP_BEQ:  encoded = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0],
                          imm[10], 7'b1100011};
      default: encoded = 32'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    word_next  = word_q;
    err_next   = 1'b0;
    if (clear) begin
      state_next = IDLE;
      ptr_next   = 8'd0;
      cnt_next   = 9'd0;
      word_next  = 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (op_sel == OP_ILLEGAL) begin
              err_next = 1'b1;
            end else begin
              word_next  = encoded;
              state_next = WRITE;
            end
          end
        end
        WRITE: begin
          // Pointer wraps 255->0 on the last write; count saturates at 256.
          ptr_next   = ptr + 8'd1;
          cnt_next   = cnt + 9'd1;
          state_next = (cnt == 9'd255) ? FULL_ST : IDLE;
        end
        FULL_ST: begin
          state_next = FULL_ST;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 8'd0;
      cnt    <= 9'd0;
      word_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      cnt    <= cnt_next;
      word_q <= word_next;
      err_q  <= err_next;
    end
  end

  assign mem_we    = (state == WRITE);
  assign mem_addr  = ptr;
  assign mem_wdata = mem_we ? word_q : 32'd0;
  assign count     = cnt;
  assign full      = (state == FULL_ST);
  assign err       = err_q;

endmodule

// File: tb/tb_codificador_instrucao.sv
// Scoreboard bench for codificador_instrucao: expected {addr, word} pairs are
// queued at drive time and popped whenever the memory write strobe is seen.
module tb_codificador_instrucao;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op_sel = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [11:0] imm = 12'd0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic        full;
  logic        err;

  logic [39:0] exp_q[$];
  logic [7:0]  exp_ptr = 8'd0;
  int          exp_count = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  codificador_instrucao dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder written with shifts and masks from the ISA field layout.
  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] d,
                                      input logic [4:0] a, input logic [4:0] b,
                                      input logic [11:0] im);
    logic [31:0] i, r1, r2, rdd;
    i = {20'd0, im}; r1 = {27'd0, a}; r2 = {27'd0, b}; rdd = {27'd0, d};
    case (op)
      3'd0: enc = (i << 20) | (r1 << 15) | (32'd2 << 12) | (rdd << 7) | 32'h03;
      3'd1: enc = ((i >> 5) << 25) | (r2 << 20) | (r1 << 15) | (32'd2 << 12)
                  | ((i & 32'd31) << 7) | 32'h23;
      3'd2: enc = 32'h4000_0000 | (r2 << 20) | (r1 << 15) | (rdd << 7) | 32'h33;
      3'd3: enc = (r2 << 20) | (r1 << 15) | (32'd4 << 12) | (rdd << 7) | 32'h33;
      3'd4: enc = (i << 20) | (r1 << 15) | (rdd << 7) | 32'h13;
      3'd5: enc = (r2 << 20) | (r1 << 15) | (32'd5 << 12) | (rdd << 7) | 32'h33;
      3'd6: enc = (((i >> 11) & 32'd1) << 31) | (((i >> 4) & 32'd63) << 25)
                  | (r2 << 20) | (r1 << 15) | ((i & 32'd15) << 8)
                  | (((i >> 10) & 32'd1) << 7) | 32'h63;
      default: enc = 32'd0;
    endcase
  endfunction

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [39:0] e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {39'd0, mem_we}, 40'd0);
      end else begin
        e = exp_q.pop_front();
        check("wdata", {8'd0, mem_wdata}, {8'd0, e[31:0]});
        check("addr", {32'd0, mem_addr}, {32'd0, e[39:32]});
        check("ready_in_write", {39'd0, in_ready}, 40'd0);
      end
    end else if (mem_we === 1'b0) begin
      check("wdata_idle", {8'd0, mem_wdata}, 40'd0);
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 40'd0, 40'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [11:0] im, input logic [31:0] exp_word);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    op_sel = op; rd = d; rs1 = a; rs2 = b; imm = im; in_valid = 1'b1;
    if (op != 3'd7) begin
      exp_q.push_back({exp_ptr, exp_word});
      exp_ptr++;
      exp_count++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_sel = 3'($urandom_range(0, 7)); rd = 5'($urandom); rs1 = 5'($urandom);
    rs2 = 5'($urandom); imm = 12'($urandom);
    @(negedge clk);
    if (op == 3'd7) begin
      check("err_pulse", {39'd0, err}, 40'd1);
      check("err_no_write", {39'd0, mem_we}, 40'd0);
    end
    @(negedge clk);
    if (op == 3'd7) check("err_one_cycle", {39'd0, err}, 40'd0);
    check("count", {31'd0, count}, 40'(exp_count));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_ptr = 8'd0;
    exp_count = 0;
    @(negedge clk);
    check("clear_count", {31'd0, count}, 40'd0);
    check("clear_full", {39'd0, full}, 40'd0);
    check("clear_ready", {39'd0, in_ready}, 40'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [4:0]  d, a, b;
    logic [11:0] im;
    bit          ok;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_we", {39'd0, mem_we}, 40'd0);
    check("rst_wdata", {8'd0, mem_wdata}, 40'd0);
    check("rst_count", {31'd0, count}, 40'd0);
    check("rst_full", {39'd0, full}, 40'd0);
    check("rst_err", {39'd0, err}, 40'd0);
    check("rst_ready", {39'd0, in_ready}, 40'd1);

    send(3'd4, 5'd1, 5'd0, 5'd0, 12'd5, 32'h0050_0093);

    do_clear();
    send(3'd0, 5'd2, 5'd1, 5'd0, 12'd4, 32'h0040_A103);
    send(3'd2, 5'd3, 5'd1, 5'd2, 12'd0, 32'h4020_81B3);

    send(3'd1, 5'd0, 5'd1, 5'd2, 12'd8, 32'h0020_A423);
    send(3'd6, 5'd0, 5'd1, 5'd2, 12'd4, 32'h0020_8463);

    send(3'd7, 5'd9, 5'd9, 5'd9, 12'd9, 32'd0);

    // Fill all 256 words with random legal instructions.
    do_clear();
    for (int n = 0; n < 256; n++) begin
      op = 3'($urandom_range(0, 6)); d = 5'($urandom); a = 5'($urandom);
      b = 5'($urandom); im = 12'($urandom);
      send(op, d, a, b, im, enc(op, d, a, b, im));
    end
    check("full_flag", {39'd0, full}, 40'd1);
    check("full_ready", {39'd0, in_ready}, 40'd0);
    check("full_count", {31'd0, count}, 40'd256);
    @(negedge clk);
    op_sel = 3'd4; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("full_ignore_count", {31'd0, count}, 40'd256);
    check("full_ignore_flag", {39'd0, full}, 40'd1);
    do_clear();
    send(3'd4, 5'd1, 5'd0, 5'd0, 12'd5, 32'h0050_0093);

    // clear beats a simultaneous request.
    @(negedge clk);
    wait_ready(ok);
    op_sel = 3'd4; rd = 5'd7; rs1 = 5'd0; imm = 12'd1;
    in_valid = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clear = 1'b0;
    exp_ptr = 8'd0; exp_count = 0;
    @(negedge clk);
    check("clr_valid_no_write", {39'd0, mem_we}, 40'd0);
    check("clr_valid_count", {31'd0, count}, 40'd0);
    @(negedge clk);
    check("clr_valid_still_idle", {39'd0, mem_we}, 40'd0);
    send(3'd3, 5'd4, 5'd5, 5'd6, 12'd0, 32'h0062_C233);

    // reset arriving during WRITE drops the write.
    @(negedge clk);
    wait_ready(ok);
    op_sel = 3'd5; rd = 5'd8; rs1 = 5'd9; rs2 = 5'd10; in_valid = 1'b1;
    exp_q.push_back({exp_ptr, enc(3'd5, 5'd8, 5'd9, 5'd10, 12'd0)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_ptr = 8'd0; exp_count = 0;
    @(negedge clk);
    check("rst_write_mem_we", {39'd0, mem_we}, 40'd0);
    check("rst_write_count", {31'd0, count}, 40'd0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 12'd5, 32'h0050_0093);

    repeat (3) @(negedge clk);
    check("queue_drained", 40'(exp_q.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
